// File: rtl/cfg_bus_arbiter_if.sv
// Requester-facing and decoder-facing signals of the shared config write port.
// The arbiter uses the slave modport; the requester side uses the master modport.
interface cfg_bus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        err;
  logic [2:0]                gnt_id;
  logic                      cfg_we;
  logic [ADDR_W-1:0]         cfg_addr;
  logic [DATA_W-1:0]         cfg_wdata;
  logic                      busy;

  modport master (
    output req, lock, req_addr, req_wdata,
    input  ack, err, gnt_id, cfg_we, cfg_addr, cfg_wdata, busy
  );

  modport slave (
    input  req, lock, req_addr, req_wdata,
    output ack, err, gnt_id, cfg_we, cfg_addr, cfg_wdata, busy
  );
endinterface

// File: rtl/cfg_bus_arbiter.sv
// Round-robin arbiter sharing one paced config write port between requesters,
// with lock ownership, lock timeout and a privileged address region.
module cfg_bus_arbiter #(
  parameter int                 NUM_REQ      = 2,
  parameter int                 ADDR_W       = 8,
  parameter int                 DATA_W       = 8,
  parameter int                 GAP_CYCLES   = 1,
  parameter logic [ADDR_W-1:0]  PROT_BASE    = 8'hC0,
  parameter logic [NUM_REQ-1:0] PRIV_MASK    = 2'b01,
  parameter int                 LOCK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cfg_bus_arbiter_if.slave bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_GAP} state_t;

  state_t              state;
  logic [2:0]          ptr;
  logic [NUM_REQ-1:0]  owner_oh;
  logic [TO_W-1:0]     to_cnt;
  logic [GAP_W-1:0]    gap_cnt;

  logic [NUM_REQ-1:0]  ack_q;
  logic [NUM_REQ-1:0]  err_q;
  logic [2:0]          gnt_id_q;
  logic                cfg_we_q;
  logic [ADDR_W-1:0]   cfg_addr_q;
  logic [DATA_W-1:0]   cfg_wdata_q;
  logic                busy_q;

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  win_oh;
  logic [2:0]          win_id;
  logic [2:0]          next_ptr;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                win_lock;
  logic                win_priv;
  logic                found;
  logic                rejected;
  logic                win_is_owner;
  logic                owner_held;

  assign owner_held = |owner_oh;
  assign eligible   = owner_held ? (bus.req & owner_oh) : bus.req;

  // First eligible index at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    idx      = 0;
    found    = 1'b0;
    win_oh   = '0;
    win_id   = '0;
    win_addr = '0;
    win_data = '0;
    win_lock = 1'b0;
    win_priv = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
        win_id      = 3'(idx);
        win_addr    = bus.req_addr[idx*ADDR_W +: ADDR_W];
        win_data    = bus.req_wdata[idx*DATA_W +: DATA_W];
        win_lock    = bus.lock[idx];
        win_priv    = PRIV_MASK[idx];
      end
    end
  end

  assign next_ptr     = (int'(win_id) == NUM_REQ - 1) ? 3'd0 : win_id + 3'd1;
  assign rejected     = (win_addr >= PROT_BASE) && !win_priv;
  assign win_is_owner = |(win_oh & owner_oh);

  // NOTE: all state and outputs here use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      owner_oh    <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      gnt_id_q    <= '0;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      ack_q    <= '0;
      err_q    <= '0;
      cfg_we_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (found) begin
            state    <= ST_WRITE;
            ptr      <= next_ptr;
            gnt_id_q <= win_id;
            ack_q    <= win_oh;
            to_cnt   <= '0;
            busy_q   <= 1'b1;
            if (rejected) begin
              err_q <= win_oh;
              if (win_is_owner) owner_oh <= '0;
            end else begin
              cfg_we_q    <= 1'b1;
              cfg_addr_q  <= win_addr;
              cfg_wdata_q <= win_data;
              if (win_lock)          owner_oh <= win_oh;
              else if (win_is_owner) owner_oh <= '0;
            end
          end else if (owner_held) begin
            // Owner is idle: count towards force-release of the lock.
            if (to_cnt == TO_LAST) begin
              owner_oh <= '0;
              to_cnt   <= '0;
              busy_q   <= 1'b0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
              busy_q <= 1'b1;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_WRITE: begin
          state   <= ST_GAP;
          gap_cnt <= GAP_LAST;
          busy_q  <= 1'b1;
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state  <= ST_IDLE;
            busy_q <= owner_held;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= owner_held;
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.cfg_we    = cfg_we_q;
  assign bus.cfg_addr  = cfg_addr_q;
  assign bus.cfg_wdata = cfg_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Scoreboard bench for cfg_bus_arbiter: stimulus pushes expected grants,
// a negedge monitor pops and compares whenever an ack is presented.
module tb_cfg_bus_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cfg_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cfg_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYCLES(1),
    .PROT_BASE(8'hC0), .PRIV_MASK(2'b01), .LOCK_TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic       r_req  [NUM_REQ];
  logic       r_lock [NUM_REQ];
  logic [7:0] r_addr [NUM_REQ];
  logic [7:0] r_data [NUM_REQ];

  assign bus.req       = {r_req[1], r_req[0]};
  assign bus.lock      = {r_lock[1], r_lock[0]};
  assign bus.req_addr  = {r_addr[1], r_addr[0]};
  assign bus.req_wdata = {r_data[1], r_data[0]};

  typedef struct {
    int         id;
    bit         err;
    logic [7:0] addr;
    logic [7:0] data;
    int         gap;   // expected cycles since previous ack, 0 = not checked
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void expect_wr(input int id, input bit err, input logic [7:0] a,
                                    input logic [7:0] d, input int gap);
    exp_t e;
    e.id = id; e.err = err; e.addr = a; e.data = d; e.gap = gap;
    sb.push_back(e);
  endfunction

  // Requester model: raise req, wait for its ack, then drop req or keep it for the next write.
  task automatic wr(input int id, input logic [7:0] a, input logic [7:0] d,
                    input logic lk, input bit last);
    bit got;
    got = 1'b0;
    r_addr[id] = a; r_data[id] = d; r_lock[id] = lk; r_req[id] = 1'b1;
    for (int c = 0; c < 60 && !got; c++) begin
      @(posedge clk); #1;
      if (bus.ack[id]) got = 1'b1;
    end
    if (!got) check($sformatf("ack_timeout_req%0d", id), 32'd0, 32'd1);
    if (last || !got) r_req[id] = 1'b0;
  endtask

  // Monitor
  int               cyc = 0;
  int               last_ack_cyc = 0;
  logic             prev_we = 1'b0;
  exp_t             me;
  logic [NUM_REQ-1:0] exp_oh;

  always @(negedge clk) begin
    cyc++;
    if (bus.cfg_we && prev_we) check("cfg_we_width", 32'd2, 32'd1);
    if (|bus.ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(bus.ack), 32'd0);
      end else begin
        me = sb.pop_front();
        exp_oh = '0;
        exp_oh[me.id] = 1'b1;
        check("ack",       32'(bus.ack),       32'(exp_oh));
        check("err",       32'(bus.err),       me.err ? 32'(exp_oh) : 32'd0);
        check("cfg_we",    32'(bus.cfg_we),    me.err ? 32'd0 : 32'd1);
        check("cfg_addr",  32'(bus.cfg_addr),  32'(me.addr));
        check("cfg_wdata", 32'(bus.cfg_wdata), 32'(me.data));
        check("gnt_id",    32'(bus.gnt_id),    32'(me.id));
        if (me.gap != 0) check("ack_spacing", 32'(cyc - last_ack_cyc), 32'(me.gap));
        last_ack_cyc = cyc;
      end
    end else if (bus.cfg_we) begin
      check("cfg_we_without_ack", 32'd1, 32'd0);
    end
    prev_we = bus.cfg_we;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_req[i] = 1'b0; r_lock[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",       32'(bus.ack),       32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    check("rst_cfg_we",    32'(bus.cfg_we),    32'd0);
    check("rst_cfg_addr",  32'(bus.cfg_addr),  32'd0);
    check("rst_cfg_wdata", 32'(bus.cfg_wdata), 32'd0);
    check("rst_gnt_id",    32'(bus.gnt_id),    32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write from requester 0, then busy through the GAP.
    expect_wr(0, 1'b0, 8'h00, 8'h10, 0);
    wr(0, 8'h00, 8'h10, 1'b0, 1'b1);
    check("busy_write", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("busy_gap", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("busy_idle", 32'(bus.busy), 32'd0);

    // Unprivileged write into the protected region: rejected, port unchanged.
    expect_wr(1, 1'b1, 8'h00, 8'h10, 0);
    wr(1, 8'hC4, 8'h33, 1'b0, 1'b1);

    // Both requesting continuously: 0,1,0,1 three cycles apart.
    expect_wr(0, 1'b0, 8'h20, 8'hA0, 0);
    expect_wr(1, 1'b0, 8'h30, 8'hB0, 3);
    expect_wr(0, 1'b0, 8'h21, 8'hA1, 3);
    expect_wr(1, 1'b0, 8'h31, 8'hB1, 3);
    fork
      begin wr(0, 8'h20, 8'hA0, 1'b0, 1'b0); wr(0, 8'h21, 8'hA1, 1'b0, 1'b1); end
      begin wr(1, 8'h30, 8'hB0, 1'b0, 1'b0); wr(1, 8'h31, 8'hB1, 1'b0, 1'b1); end
    join

    // Privileged requester may write the protected region.
    expect_wr(0, 1'b0, 8'hC4, 8'h55, 0);
    wr(0, 8'hC4, 8'h55, 1'b0, 1'b1);

    // Locked window update by requester 1 while requester 0 waits.
    expect_wr(1, 1'b0, 8'h01, 8'hD1, 0);
    expect_wr(1, 1'b0, 8'h05, 8'hD5, 3);
    expect_wr(1, 1'b0, 8'h09, 8'hD9, 3);
    expect_wr(0, 1'b0, 8'h40, 8'h44, 3);
    wr(1, 8'h01, 8'hD1, 1'b1, 1'b0);
    fork
      wr(0, 8'h40, 8'h44, 1'b0, 1'b1);
      begin wr(1, 8'h05, 8'hD5, 1'b1, 1'b0); wr(1, 8'h09, 8'hD9, 1'b0, 1'b1); end
    join

    // Lock taken then abandoned: force-released after 16 idle cycles.
    expect_wr(0, 1'b0, 8'h50, 8'h60, 0);
    expect_wr(1, 1'b0, 8'h70, 8'h77, 19);
    wr(0, 8'h50, 8'h60, 1'b1, 1'b1);
    fork
      wr(1, 8'h70, 8'h77, 1'b0, 1'b1);
      begin
        repeat (17) @(posedge clk);
        #1;
        check("busy_lock_held", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        check("busy_lock_timeout", 32'(bus.busy), 32'd0);
        check("no_grant_at_release", 32'(bus.ack), 32'd0);
      end
    join

    // Reset asserted during the WRITE cycle of a locking write.
    r_addr[0] = 8'h80; r_data[0] = 8'h88; r_lock[0] = 1'b1; r_req[0] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (bus.cfg_we) got = 1'b1;
    end
    check("rst_test_write_seen", 32'(got), 32'd1);
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) r_req[i] = 1'b0;
    #1;
    check("midrst_cfg_we", 32'(bus.cfg_we), 32'd0);
    check("midrst_ack",    32'(bus.ack),    32'd0);
    check("midrst_err",    32'(bus.err),    32'd0);
    check("midrst_busy",   32'(bus.busy),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("postrst_gnt_id",   32'(bus.gnt_id),   32'd0);
    check("postrst_cfg_addr", 32'(bus.cfg_addr), 32'd0);

    // Pointer back at 0 and no lock owner: 0 then 1, three cycles apart.
    expect_wr(0, 1'b0, 8'h90, 8'h99, 0);
    expect_wr(1, 1'b0, 8'hA0, 8'hAA, 3);
    fork
      wr(0, 8'h90, 8'h99, 1'b0, 1'b1);
      wr(1, 8'hA0, 8'hAA, 1'b0, 1'b1);
    join

    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
